quad_debounce: RTL

Input conditioning stage for the rotary encoder path. It takes the two raw mechanical quadrature contacts, synchronises them into the `clk` domain, and removes contact bounce by integrating samples on a slow strobe. It drives clean `a`/`b` levels into the encoder counter directly downstream. It also reports a saturating count of rejected bounce events for debug.

---
 rtl/quad_debounce.sv | 111 +++++++++++
 1 files changed

// File: rtl/quad_debounce.sv
// quad_debounce: conditions the two raw quadrature contacts of the rotary
// encoder. Each contact is synchronised with two flops, then integrated on a
// slow sample strobe so that only a level held for HIST consecutive samples
// reaches the clean a/b outputs. Integrations abandoned before completion are
// counted (saturating at 255) for bounce diagnostics.
module quad_debounce #(
  parameter int STROBE_DIV = 1000,
  parameter int HIST       = 8,
  parameter int DIVW       = $clog2(STROBE_DIV + 1),
  parameter int CNTW       = $clog2(HIST + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a,
  output logic       b,
  output logic       strobe,
  output logic [7:0] reject_count
);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(STROBE_DIV - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HIST - 1);

  // Bit 0 carries channel A, bit 1 carries channel B throughout.
  logic [1:0]           r_sync_p0;
  logic [1:0]           r_sync_p1;
  logic [DIVW-1:0]      r_div;
  logic                 w_strobe;
  logic [1:0][CNTW-1:0] r_cnt;
  logic [1:0][CNTW-1:0] w_cnt_nxt;
  logic [1:0]           r_out;
  logic [1:0]           w_out_nxt;
  logic [1:0]           w_rej;
  logic [1:0]           w_rej_n;
  logic [7:0]           r_reject_count;

  // Add 0..2 rejections to the debug counter, clamping at 255 instead of
  // wrapping so a noisy contact never makes the count look small again.
  function automatic logic [7:0] sat_add(input logic [7:0] acc,
                                         input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Stage p0/p1: two-flop synchroniser for both raw contacts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= {b_raw, a_raw};
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_strobe = (r_div == DIV_LAST);

  // Prescaler: free-running 0..STROBE_DIV-1, strobe in its last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_strobe) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIVW'(1);
    end
  end

  // Per-channel integration decision for the current sample.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_out_nxt = r_out;
    w_rej     = '0;
    for (int i = 0; i < 2; i++) begin
      if (r_sync_p1[i] == r_out[i]) begin
        if (r_cnt[i] != '0) begin
          w_cnt_nxt[i] = '0;
          w_rej[i]     = 1'b1;
        end
      end else if (r_cnt[i] == CNT_LAST) begin
        w_out_nxt[i] = r_sync_p1[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNTW'(1);
      end
    end
  end

  assign w_rej_n = {1'b0, w_rej[0]} + {1'b0, w_rej[1]};

  // Integrator state, clean outputs and reject counter advance only on strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_out          <= '0;
      r_reject_count <= '0;
    end else if (w_strobe) begin
      r_cnt          <= w_cnt_nxt;
      r_out          <= w_out_nxt;
      r_reject_count <= sat_add(r_reject_count, w_rej_n);
    end
  end

  assign a            = r_out[0];
  assign b            = r_out[1];
  assign strobe       = w_strobe;
  assign reject_count = r_reject_count;

endmodule
